// File: rtl/imem_prog_loader.sv
// imem_prog_loader: writer side of the instruction memory.
// Receives a framed byte stream from a host link (valid/ready), assembles
// little-endian 16-bit instruction words, writes them to consecutive IM
// addresses and keeps the core in reset until a frame with a good checksum
// has been fully loaded.
//
// Frame: LEN (N, 0 means 2**ADDR_W words), N x {lo, hi}, CHK.
// The frame is good when the 8-bit sum of every byte, CHK included, is zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset, waiting for start; core held in reset
// S_LEN   | waiting for the word-count byte
// S_LO    | waiting for the low byte of the next instruction word
// S_HI    | waiting for the high byte of the next instruction word
// S_WR    | one-cycle IM write strobe; no byte accepted
// S_CHK   | waiting for the checksum byte
// S_DONE  | frame good: done=1, core released; start begins a new session
// S_ERR   | checksum bad: err=1, core stays held; start begins a new session

module imem_prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LO,
    S_HI,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [7:0]      sum;
  logic [LW-1:0]   len_words;

  logic            take;
  logic [7:0]      sum_next;
  logic [LW-1:0]   len_decoded;
  logic [LW-1:0]   loaded_next;

  assign take        = rx_valid & rx_ready;
  assign sum_next    = sum + rx_data;
  assign loaded_next = words_loaded + LW'(1);

  // Decode the LEN byte; zero stands for a full memory of 2**ADDR_W words.
  always_comb begin
    len_decoded = LW'(rx_data);
    if (rx_data == 8'd0) begin
      len_decoded = {1'b1, {ADDR_W{1'b0}}};
    end
  end

  // Session FSM; every output is a register updated alongside the state so
  // that rx_ready, busy and core_rstn always match the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      sum          <= 8'd0;
      len_words    <= '0;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 16'd0;
      core_rstn    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            sum          <= 8'd0;
            words_loaded <= '0;
            imem_addr    <= BASE_ADDR;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            core_rstn    <= 1'b0;
          end
        end

        S_LEN: begin
          if (take) begin
            len_words <= len_decoded;
            sum       <= sum_next;
            state     <= S_LO;
          end
        end

        S_LO: begin
          if (take) begin
            imem_wdata[7:0] <= rx_data;
            sum             <= sum_next;
            state           <= S_HI;
          end
        end

        S_HI: begin
          if (take) begin
            imem_wdata[15:8] <= rx_data;
            sum              <= sum_next;
            imem_we          <= 1'b1;
            rx_ready         <= 1'b0;
            state            <= S_WR;
          end
        end

        // Address and data were settled before the strobe and are only
        // advanced here, after the write cycle has completed.
        S_WR: begin
          imem_addr    <= imem_addr + ADDR_W'(1);
          words_loaded <= loaded_next;
          rx_ready     <= 1'b1;
          if (loaded_next < len_words) begin
            state <= S_LO;
          end else begin
            state <= S_CHK;
          end
        end

        S_CHK: begin
          if (take) begin
            sum      <= sum_next;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (sum_next == 8'd0) begin
              done      <= 1'b1;
              core_rstn <= 1'b1;
              state     <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: two instances share the host stimulus,
// one at BASE_ADDR=0 and one at BASE_ADDR=FE to exercise address wrap.
module tb_imem_prog_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;

  logic          a_rx_ready, a_imem_we, a_core_rstn, a_busy, a_done, a_err;
  logic [AW-1:0] a_imem_addr;
  logic [15:0]   a_imem_wdata;
  logic [AW:0]   a_words_loaded;

  logic          f_rx_ready, f_imem_we, f_core_rstn, f_busy, f_done, f_err;
  logic [AW-1:0] f_imem_addr;
  logic [15:0]   f_imem_wdata;
  logic [AW:0]   f_words_loaded;

  int checks = 0;
  int failures = 0;

  imem_prog_loader #(.ADDR_W(AW), .BASE_ADDR(8'h00)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(a_rx_ready), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
    .imem_wdata(a_imem_wdata), .core_rstn(a_core_rstn), .busy(a_busy),
    .done(a_done), .err(a_err), .words_loaded(a_words_loaded)
  );

  imem_prog_loader #(.ADDR_W(AW), .BASE_ADDR(8'hFE)) u_dut_fe (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(f_rx_ready), .imem_we(f_imem_we), .imem_addr(f_imem_addr),
    .imem_wdata(f_imem_wdata), .core_rstn(f_core_rstn), .busy(f_busy),
    .done(f_done), .err(f_err), .words_loaded(f_words_loaded)
  );

  always #5 clk = ~clk;

  // Instruction memory models and write-strobe counters
  logic [15:0]   mem_a [0:255];
  logic [15:0]   mem_f [0:255];
  logic [AW-1:0] addr_log_f [0:1023];
  int we_cnt_a = 0;
  int we_cnt_f = 0;

  always @(posedge clk) begin
    if (a_imem_we) begin
      mem_a[a_imem_addr] <= a_imem_wdata;
      we_cnt_a <= we_cnt_a + 1;
    end
    if (f_imem_we) begin
      mem_f[f_imem_addr] <= f_imem_wdata;
      addr_log_f[we_cnt_f % 1024] <= f_imem_addr;
      we_cnt_f <= we_cnt_f + 1;
    end
  end

  // Frame under construction and its expected words
  logic [7:0]  frame [0:600];
  int          frame_len;
  logic [15:0] exp_w [0:255];

  task automatic build_frame(input int n, input logic [15:0] base, input logic [15:0] step,
                             input bit bad);
    logic [7:0]  s;
    logic [15:0] w;
    s = 8'(n);
    frame[0] = 8'(n);
    for (int i = 0; i < n; i++) begin
      w = base + 16'(i) * step;
      exp_w[i] = w;
      frame[1 + 2*i] = w[7:0];
      frame[2 + 2*i] = w[15:8];
      s = s + w[7:0] + w[15:8];
    end
    frame[1 + 2*n] = 8'(8'd0 - s) + (bad ? 8'd1 : 8'd0);
    frame_len = 2 + 2*n;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    waited = 0;
    while (!a_rx_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout byte=%02h ready=%0b required=1", b, a_rx_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int k = 0; k < frame_len; k++) begin
      send_byte(frame[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    checks++;
    if ({a_rx_ready, a_imem_we, a_core_rstn, a_busy, a_done, a_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%06b required=000000",
               {a_rx_ready, a_imem_we, a_core_rstn, a_busy, a_done, a_err});
    end
    checks++;
    if (a_imem_addr !== 8'h00 || f_imem_addr !== 8'hFE) begin
      failures++;
      $display("FAIL reset_addr got=%02h/%02h required=00/FE", a_imem_addr, f_imem_addr);
    end
    checks++;
    if (a_imem_wdata !== 16'h0 || a_words_loaded !== 9'h0) begin
      failures++;
      $display("FAIL reset_data got=%04h/%03h required=0000/000", a_imem_wdata, a_words_loaded);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    int w0;
    build_frame(3, 16'h2211, 16'h2222, 1'b0);
    w0 = we_cnt_a;
    pulse_start();
    checks++;
    if ({a_busy, a_rx_ready, a_core_rstn, a_done} !== 4'b1100) begin
      failures++;
      $display("FAIL basic_after_start got=%04b required=1100",
               {a_busy, a_rx_ready, a_core_rstn, a_done});
    end
    for (int k = 0; k < 3; k++) send_byte(frame[k], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (a_imem_we !== 1'b1 || a_rx_ready !== 1'b0 || a_imem_addr !== 8'h00 ||
        a_imem_wdata !== 16'h2211) begin
      failures++;
      $display("FAIL basic_write_cycle we=%0b rdy=%0b addr=%02h data=%04h required 1/0/00/2211",
               a_imem_we, a_rx_ready, a_imem_addr, a_imem_wdata);
    end
    for (int k = 3; k < frame_len; k++) send_byte(frame[k], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({a_done, a_err, a_core_rstn, a_busy} !== 4'b1010) begin
      failures++;
      $display("FAIL basic_status got=%04b required=1010", {a_done, a_err, a_core_rstn, a_busy});
    end
    checks++;
    if (we_cnt_a - w0 !== 3 || a_words_loaded !== 9'd3) begin
      failures++;
      $display("FAIL basic_count we=%0d words=%0d required=3/3", we_cnt_a - w0, a_words_loaded);
    end
    checks++;
    if (mem_a[0] !== 16'h2211 || mem_a[1] !== 16'h4433 || mem_a[2] !== 16'h6655) begin
      failures++;
      $display("FAIL basic_mem got=%04h %04h %04h required=2211 4433 6655",
               mem_a[0], mem_a[1], mem_a[2]);
    end
  endtask

  task automatic test_bad_chk();
    int w0;
    build_frame(3, 16'h2211, 16'h2222, 1'b1);
    w0 = we_cnt_a;
    pulse_start();
    send_frame(0);
    checks++;
    if ({a_done, a_err, a_core_rstn, a_busy} !== 4'b0100) begin
      failures++;
      $display("FAIL badchk_status got=%04b required=0100", {a_done, a_err, a_core_rstn, a_busy});
    end
    checks++;
    if (we_cnt_a - w0 !== 3 || a_words_loaded !== 9'd3) begin
      failures++;
      $display("FAIL badchk_count we=%0d words=%0d required=3/3", we_cnt_a - w0, a_words_loaded);
    end
  endtask

  task automatic test_wrap();
    int f0;
    build_frame(3, 16'hBEEF, 16'h1111, 1'b0);
    f0 = we_cnt_f;
    pulse_start();
    send_frame(0);
    checks++;
    if (f_done !== 1'b1 || f_words_loaded !== 9'd3) begin
      failures++;
      $display("FAIL wrap_status done=%0b words=%0d required=1/3", f_done, f_words_loaded);
    end
    checks++;
    if (addr_log_f[f0 % 1024] !== 8'hFE || addr_log_f[(f0+1) % 1024] !== 8'hFF ||
        addr_log_f[(f0+2) % 1024] !== 8'h00) begin
      failures++;
      $display("FAIL wrap_addr got=%02h %02h %02h required=FE FF 00", addr_log_f[f0 % 1024],
               addr_log_f[(f0+1) % 1024], addr_log_f[(f0+2) % 1024]);
    end
    checks++;
    if (mem_f[8'hFE] !== 16'hBEEF || mem_f[8'hFF] !== 16'hD000 || mem_f[8'h00] !== 16'hE111) begin
      failures++;
      $display("FAIL wrap_mem got=%04h %04h %04h required=BEEF D000 E111",
               mem_f[8'hFE], mem_f[8'hFF], mem_f[8'h00]);
    end
  endtask

  task automatic test_full();
    int w0;
    int bad_a;
    int bad_f;
    build_frame(256, 16'hA500, 16'h0001, 1'b0);
    w0 = we_cnt_a;
    pulse_start();
    send_frame(0);
    checks++;
    if (we_cnt_a - w0 !== 256 || a_words_loaded !== 9'h100) begin
      failures++;
      $display("FAIL full_count we=%0d words=%03h required=256/100", we_cnt_a - w0, a_words_loaded);
    end
    checks++;
    if ({a_done, a_err, a_core_rstn} !== 3'b101) begin
      failures++;
      $display("FAIL full_status got=%03b required=101", {a_done, a_err, a_core_rstn});
    end
    bad_a = 0;
    bad_f = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_a[i] !== 16'hA500 + 16'(i)) bad_a++;
      if (mem_f[(254 + i) % 256] !== 16'hA500 + 16'(i)) bad_f++;
    end
    checks++;
    if (bad_a !== 0 || bad_f !== 0) begin
      failures++;
      $display("FAIL full_mem wrong_words=%0d/%0d required=0/0", bad_a, bad_f);
    end
  endtask

  task automatic test_gaps_start();
    int w0;
    int bad;
    build_frame(5, 16'h1357, 16'h0F0F, 1'b0);
    w0 = we_cnt_a;
    pulse_start();
    for (int k = 0; k < frame_len; k++) begin
      if (k == 4) begin
        pulse_start();
        checks++;
        if (a_busy !== 1'b1 || a_words_loaded !== 9'd1) begin
          failures++;
          $display("FAIL gaps_start_ignored busy=%0b words=%0d required=1/1", a_busy, a_words_loaded);
        end
      end
      send_byte(frame[k], int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({a_done, a_err, a_core_rstn} !== 3'b101 || a_words_loaded !== 9'd5) begin
      failures++;
      $display("FAIL gaps_status flags=%03b words=%0d required=101/5",
               {a_done, a_err, a_core_rstn}, a_words_loaded);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) if (mem_a[i] !== exp_w[i]) bad++;
    checks++;
    if (bad !== 0 || we_cnt_a - w0 !== 5) begin
      failures++;
      $display("FAIL gaps_mem wrong_words=%0d we=%0d required=0/5", bad, we_cnt_a - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    build_frame(3, 16'hCAFE, 16'h0101, 1'b0);
    w0 = we_cnt_a;
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(frame[k], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (we_cnt_a - w0 !== 2 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre we=%0d busy=%0b required=2/1", we_cnt_a - w0, a_busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({a_rx_ready, a_imem_we, a_core_rstn, a_busy, a_done, a_err} !== 6'b0 ||
        a_imem_addr !== 8'h00 || a_imem_wdata !== 16'h0 || a_words_loaded !== 9'h0) begin
      failures++;
      $display("FAIL rstmid_outputs flags=%06b addr=%02h data=%04h words=%0d required=0/00/0000/0",
               {a_rx_ready, a_imem_we, a_core_rstn, a_busy, a_done, a_err},
               a_imem_addr, a_imem_wdata, a_words_loaded);
    end
    @(negedge clk);
    rstn = 1'b1;
    build_frame(3, 16'h0A0B, 16'h1010, 1'b0);
    pulse_start();
    send_frame(1);
    checks++;
    if ({a_done, a_core_rstn} !== 2'b11 || mem_a[0] !== 16'h0A0B || mem_a[1] !== 16'h1A1B ||
        mem_a[2] !== 16'h2A2B) begin
      failures++;
      $display("FAIL rstmid_reload flags=%02b mem=%04h %04h %04h required=11 0A0B 1A1B 2A2B",
               {a_done, a_core_rstn}, mem_a[0], mem_a[1], mem_a[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_wrap();
    test_full();
    test_gaps_start();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
